// File: rtl/acc_stokes_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_stokes_multi_if
// Description : Sample-in / spectrum-out bus of the multi-channel Stokes
//               integrator.
//               master : the producer/consumer side (drives num_acc, in_*;
//                        observes out_*, seq_err, int_cnt)
//               slave  : the integrator itself
//               num_acc   16        spectra per integration (0 treated as 1)
//               in_valid  1         input sample valid
//               in_bin    BIN_W     bin index of the input sample
//               in_data   NCH*IN_W  channel k at [k*IN_W +: IN_W]
//               out_valid 1         integrated bin valid
//               out_bin   BIN_W     bin index of the output
//               out_first 1         high with the bin 0 output
//               out_data  NCH*ACC_W channel k at [k*ACC_W +: ACC_W]
//               out_sat   NCH       per-channel sticky saturation flag
//               seq_err   1         one-cycle pulse on a bin sequence error
//               int_cnt   16        completed integrations (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_stokes_multi_if #(
    parameter int NCH   = 4,
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int BIN_W = 9
);
    logic [15:0]           num_acc;
    logic                  in_valid;
    logic [BIN_W-1:0]      in_bin;
    logic [NCH*IN_W-1:0]   in_data;
    logic                  out_valid;
    logic [BIN_W-1:0]      out_bin;
    logic                  out_first;
    logic [NCH*ACC_W-1:0]  out_data;
    logic [NCH-1:0]        out_sat;
    logic                  seq_err;
    logic [15:0]           int_cnt;

    modport master (
        output num_acc, in_valid, in_bin, in_data,
        input  out_valid, out_bin, out_first, out_data, out_sat, seq_err, int_cnt
    );

    modport slave (
        input  num_acc, in_valid, in_bin, in_data,
        output out_valid, out_bin, out_first, out_data, out_sat, seq_err, int_cnt
    );
endinterface
`default_nettype wire

// File: rtl/acc_stokes_multi.sv
`default_nettype none
// ============================================================================
// Module      : acc_stokes_multi
// Description : Multi-channel spectral integrator for Stokes products.
//               Accumulates NCH channels per FFT bin over num_acc spectra in
//               on-chip RAM, with per-channel signed/unsigned saturation,
//               bin sequence checking with resync and an integration counter.
//               The integrated spectrum streams out, bin ordered, while the
//               final spectrum of each integration arrives.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - acc_stokes_multi_if.slave (samples in, sums out,
//                      seq_err, int_cnt, num_acc)
// Revision    : 1.0 - initial release
// ============================================================================
module acc_stokes_multi #(
    parameter int             NCH         = 4,
    parameter int             IN_W        = 16,
    parameter int             ACC_W       = 32,
    parameter int             BIN_W       = 9,       // must be >= 2
    parameter logic [NCH-1:0] SIGNED_MASK = 4'b1110
) (
    input  wire logic          clk,
    input  wire logic          rst,
    acc_stokes_multi_if.slave  bus
);
    localparam int               c_DEPTH    = 1 << BIN_W;
    localparam int               c_WORD_W   = ACC_W + 1;          // sum + sticky sat bit
    localparam int               c_MEM_W    = NCH * c_WORD_W;
    localparam logic [BIN_W-1:0] c_LAST_BIN = BIN_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t           r_state, w_state_nxt;
    logic [15:0]      r_frame, w_frame_nxt;
    logic [15:0]      r_n,     w_n_nxt;
    logic [BIN_W-1:0] r_exp,   w_exp_nxt;
    logic [15:0]      r_int_cnt, w_cnt_nxt;

    logic             w_start, w_acc_en, w_err, w_take, w_first, w_last;
    logic [15:0]      w_cur_frame, w_cur_n;
    wire  [15:0]      w_n_new = (bus.num_acc == 16'd0) ? 16'd1 : bus.num_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_n       <= 16'd1;
            r_exp     <= '0;
            r_int_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_n       <= w_n_nxt;
            r_exp     <= w_exp_nxt;
            r_int_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_n_nxt     = r_n;
        w_exp_nxt   = r_exp;
        w_cnt_nxt   = r_int_cnt;
        w_start     = 1'b0;
        w_acc_en    = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && bus.in_bin == '0)
                    w_start = 1'b1;
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    if (bus.in_bin == r_exp) begin
                        w_acc_en = 1'b1;
                    end else begin
                        // Out-of-order bin: abandon the integration; a bin 0
                        // is taken straight away as the start of a new one.
                        w_err = 1'b1;
                        if (bus.in_bin == '0)
                            w_start = 1'b1;
                        else
                            w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Frame position of the sample being accepted this cycle; a start
        // sample always belongs to frame 0 of a freshly latched length.
        w_take      = w_start | w_acc_en;
        w_cur_frame = w_start ? 16'd0   : r_frame;
        w_cur_n     = w_start ? w_n_new : r_n;
        w_first     = (w_cur_frame == 16'd0);
        w_last      = (w_cur_frame == w_cur_n - 16'd1);

        if (w_start) begin
            w_state_nxt = ST_ACC;
            w_n_nxt     = w_n_new;
            w_frame_nxt = '0;
        end

        if (w_take) begin
            w_exp_nxt = bus.in_bin + 1'b1;
            if (bus.in_bin == c_LAST_BIN) begin
                if (w_last) begin
                    w_frame_nxt = '0;
                    w_cnt_nxt   = r_int_cnt + 16'd1;
                    w_n_nxt     = w_n_new;        // length for the next integration
                end else begin
                    w_frame_nxt = w_cur_frame + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S0: RAM read, sample captured alongside
    // ------------------------------------------------------------------
    logic [c_MEM_W-1:0]    r_mem [c_DEPTH];
    logic [c_MEM_W-1:0]    r_rd;
    logic                  r_s1_valid, r_s1_err, r_s1_first, r_s1_last;
    logic [BIN_W-1:0]      r_s1_bin;
    logic [NCH*IN_W-1:0]   r_s1_data;

    wire  [c_MEM_W-1:0]    w_wr_word;
    wire  [NCH*ACC_W-1:0]  w_sum;
    wire  [NCH-1:0]        w_sat;
    // The last frame's sums leave on the output and are never read back,
    // so they are not written.
    wire                   w_wr_en = r_s1_valid & ~r_s1_last & ~rst;

    // A bin recurs no sooner than 2^BIN_W >= 4 cycles later, after its
    // write-back has landed, so no read/write bypass is needed.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_s1_bin] <= w_wr_word;
        r_rd <= r_mem[bus.in_bin];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bin   <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_take;
            r_s1_err   <= w_err;
            if (w_take) begin
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_s1_bin   <= bus.in_bin;
                r_s1_data  <= bus.in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: per-channel add with saturation
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            localparam bit c_SGN = SIGNED_MASK[k];

            wire [IN_W-1:0]  w_in      = r_s1_data[k*IN_W +: IN_W];
            // Frame 0 ignores stale RAM contents (never cleared by reset).
            wire [ACC_W-1:0] w_old     = r_s1_first ? '0 : r_rd[k*c_WORD_W +: ACC_W];
            wire             w_old_sat = ~r_s1_first & r_rd[k*c_WORD_W + ACC_W];
            wire [ACC_W:0]   w_in_ext  = c_SGN ? {{(ACC_W+1-IN_W){w_in[IN_W-1]}}, w_in}
                                               : {{(ACC_W+1-IN_W){1'b0}}, w_in};
            wire [ACC_W:0]   w_old_ext = c_SGN ? {w_old[ACC_W-1], w_old} : {1'b0, w_old};
            wire [ACC_W:0]   w_raw     = w_in_ext + w_old_ext;
            // One guard bit: signed overflow shows as disagreeing top bits,
            // unsigned overflow as a carry out.
            wire             w_ovf     = c_SGN ? (w_raw[ACC_W] != w_raw[ACC_W-1]) : w_raw[ACC_W];
            wire [ACC_W-1:0] w_clamp   = !w_ovf ? w_raw[ACC_W-1:0]
                                       : !c_SGN ? {ACC_W{1'b1}}
                                       : w_raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                      : {1'b0, {(ACC_W-1){1'b1}}};
            wire             w_sat_k   = w_old_sat | w_ovf;

            assign w_sum[k*ACC_W +: ACC_W]        = w_clamp;
            assign w_sat[k]                       = w_sat_k;
            assign w_wr_word[k*c_WORD_W +: c_WORD_W] = {w_sat_k, w_clamp};
        end
    endgenerate

    // ------------------------------------------------------------------
    // S2: output registers (updated only for last-frame samples)
    // ------------------------------------------------------------------
    logic                 r_out_valid, r_out_first, r_seq_err;
    logic [BIN_W-1:0]     r_out_bin;
    logic [NCH*ACC_W-1:0] r_out_data;
    logic [NCH-1:0]       r_out_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_bin   <= '0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid & r_s1_last;
            r_seq_err   <= r_s1_err;
            if (r_s1_valid && r_s1_last) begin
                r_out_bin   <= r_s1_bin;
                r_out_first <= (r_s1_bin == '0);
                r_out_data  <= w_sum;
                r_out_sat   <= w_sat;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_bin   = r_out_bin;
    assign bus.out_first = r_out_first;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.seq_err   = r_seq_err;
    assign bus.int_cnt   = r_int_cnt;
endmodule
`default_nettype wire

// File: tb/tb_acc_stokes_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_stokes_multi
// Description : Self-checking bench for acc_stokes_multi (4 channels, 8 bins,
//               17-bit accumulators so saturation is reachable). A behavioural
//               model queues expected outputs and seq_err pulses as stimulus
//               is driven; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_stokes_multi;
    localparam int             NCH         = 4;
    localparam int             IN_W        = 16;
    localparam int             ACC_W       = 17;
    localparam int             BIN_W       = 3;
    localparam int             NB          = 1 << BIN_W;
    localparam logic [NCH-1:0] SIGNED_MASK = 4'b1110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_stokes_multi_if #(.NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .BIN_W(BIN_W)) bus ();

    acc_stokes_multi #(
        .NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .BIN_W(BIN_W), .SIGNED_MASK(SIGNED_MASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [BIN_W-1:0]     bin;
        logic [NCH*ACC_W-1:0] data;
        logic [NCH-1:0]       sat;
        logic                 first;
        int                   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit     m_acc;
    int     m_exp, m_frame, m_n, m_cnt;
    longint m_sum [NB][NCH];
    bit     m_sat [NB][NCH];

    function automatic longint ext(input int ch, input logic [IN_W-1:0] v);
        if (SIGNED_MASK[ch]) return longint'($signed(v));
        return longint'(v);
    endfunction

    task automatic model_sample(input int bin, input logic [NCH*IN_W-1:0] d);
        bit     start = 0, take = 0, first, last, sat;
        longint s, lo, hi;
        exp_t   e;
        if (!m_acc) begin
            start = (bin == 0);
        end else if (bin == m_exp) begin
            take = 1;
        end else begin
            err_q.push_back(cyc + 2);
            if (bin == 0) start = 1;
            else m_acc = 0;
        end
        if (start) begin
            m_acc   = 1;
            m_n     = (bus.num_acc == 0) ? 1 : int'(bus.num_acc);
            m_frame = 0;
            take    = 1;
        end
        if (!take) return;
        first   = (m_frame == 0);
        last    = (m_frame == m_n - 1);
        e.bin   = BIN_W'(bin);
        e.first = (bin == 0);
        e.cyc   = cyc + 2;
        e.data  = '0;
        e.sat   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            s   = (first ? 64'sd0 : m_sum[bin][ch]) + ext(ch, d[ch*IN_W +: IN_W]);
            sat = first ? 1'b0 : m_sat[bin][ch];
            if (SIGNED_MASK[ch]) begin
                hi = (64'sd1 <<< (ACC_W-1)) - 1;
                lo = -(hi + 1);
            end else begin
                hi = (64'sd1 <<< ACC_W) - 1;
                lo = 0;
            end
            if (s > hi) begin s = hi; sat = 1; end
            if (s < lo) begin s = lo; sat = 1; end
            m_sum[bin][ch] = s;
            m_sat[bin][ch] = sat;
            e.data[ch*ACC_W +: ACC_W] = s[ACC_W-1:0];
            e.sat[ch] = sat;
        end
        if (last) exp_q.push_back(e);
        m_exp = (bin + 1) % NB;
        if (bin == NB - 1) begin
            if (last) begin
                m_frame = 0;
                m_cnt   = (m_cnt + 1) & 16'hFFFF;
                m_n     = (bus.num_acc == 0) ? 1 : int'(bus.num_acc);
            end else begin
                m_frame++;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int bin, input logic [NCH*IN_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_bin   = BIN_W'(bin);
        bus.in_data  = d;
        model_sample(bin, d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [NCH*IN_W-1:0] pattern(input int p, input int bin);
        logic [IN_W-1:0] c0, c1, c2, c3;
        case (p)
            0: begin c0 = IN_W'(bin + 1); c1 = 16'hFFFF; c2 = IN_W'(bin * 300); c3 = IN_W'(-bin); end
            1: begin c0 = 16'h8000; c1 = 16'h8000; c2 = 16'h7FFF; c3 = 16'h0001; end
            2: begin c0 = 16'hFFFF; c1 = 16'h8000; c2 = 16'h7FFF; c3 = 16'hFFFF; end
            3: begin c0 = 16'h0001; c1 = 16'h0001; c2 = 16'h0002; c3 = 16'h0003; end
            default: begin
                c0 = IN_W'($urandom); c1 = IN_W'($urandom);
                c2 = IN_W'($urandom); c3 = IN_W'($urandom);
            end
        endcase
        return {c3, c2, c1, c0};
    endfunction

    task automatic spectrum(input int p, input bit gaps);
        for (int b = 0; b < NB; b++) begin
            if (gaps) idle($urandom_range(0, 2));
            send(b, pattern(p, b));
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        // Anything still in the pipeline at the reset edge is dropped.
        exp_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_acc   = 0;
        m_cnt   = 0;
        m_exp   = 0;
        m_frame = 0;
    endtask

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check_value("missing_out_valid", 0, 1);
            void'(exp_q.pop_front());
        end
        if (err_q.size() > 0 && err_q[0] < cyc) begin
            check_value("missing_seq_err", 0, 1);
            void'(err_q.pop_front());
        end
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("out_bin",     bus.out_bin,   mon_e.bin);
                check_value("out_data",    bus.out_data,  mon_e.data);
                check_value("out_sat",     bus.out_sat,   mon_e.sat);
                check_value("out_first",   bus.out_first, mon_e.first);
                check_value("out_latency", cyc,           mon_e.cyc);
            end
        end
        if (bus.seq_err) begin
            if (err_q.size() == 0) check_value("unexpected_seq_err", 1, 0);
            else                   check_value("seq_err_timing", cyc, err_q.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        bus.num_acc  = 16'd4;
        bus.in_valid = 1'b0;
        bus.in_bin   = '0;
        bus.in_data  = '0;
        m_acc = 0; m_cnt = 0; m_exp = 0; m_frame = 0; m_n = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", bus.out_valid, 0);
        check_value("rst_seq_err",   bus.seq_err,   0);
        check_value("rst_int_cnt",   bus.int_cnt,   0);
        check_value("rst_out_data",  bus.out_data,  0);
        check_value("rst_out_bin",   bus.out_bin,   0);
        check_value("rst_out_sat",   bus.out_sat,   0);
        check_value("rst_out_first", bus.out_first, 0);
        rst = 1'b0;
        idle(2);

        // 4-spectrum integration; num_acc change mid-way applies only next time
        repeat (3) spectrum(0, 1'b0);
        bus.num_acc = 16'd0;
        spectrum(0, 1'b0);
        check_value("int_cnt_acc4", bus.int_cnt, 1);

        // num_acc = 0 and 1: pass-through with sign/zero extension
        spectrum(1, 1'b0);
        bus.num_acc = 16'd1;
        spectrum(1, 1'b0);
        bus.num_acc = 16'd3;
        spectrum(1, 1'b0);
        check_value("int_cnt_pass", bus.int_cnt, 4);

        // Saturation over 3 spectra, then a clean integration clears the flags
        repeat (3) spectrum(2, 1'b0);
        repeat (2) spectrum(3, 1'b0);
        bus.num_acc = 16'd5;
        spectrum(3, 1'b0);
        check_value("int_cnt_sat", bus.int_cnt, 6);

        // Sequence error in frame 1 (bins 0,1,2,5), stray bins while idle,
        // then an error on bin 0 that restarts immediately
        spectrum(0, 1'b0);
        send(0, pattern(0, 0));
        send(1, pattern(0, 1));
        send(2, pattern(0, 2));
        send(5, pattern(0, 5));
        send(6, pattern(0, 6));
        send(7, pattern(0, 7));
        idle(3);
        send(0, pattern(4, 0));
        send(1, pattern(4, 1));
        send(0, pattern(4, 0));
        for (int b = 1; b < NB; b++) send(b, pattern(4, b));
        bus.num_acc = 16'd2;
        repeat (4) spectrum(4, 1'b1);
        idle(3);
        check_value("int_cnt_gaps", bus.int_cnt, 7);

        // Reset during the last frame, then a fresh 2-spectrum integration
        spectrum(4, 1'b0);
        for (int b = 0; b < 3; b++) send(b, pattern(4, b));
        do_reset();
        idle(2);
        check_value("post_rst_out_valid", bus.out_valid, 0);
        check_value("post_rst_int_cnt",   bus.int_cnt,   0);
        check_value("post_rst_seq_err",   bus.seq_err,   0);
        repeat (2) spectrum(4, 1'b1);
        idle(4);
        check_value("int_cnt_after_rst", bus.int_cnt, 1);

        idle(4);
        check_value("pending_outputs", exp_q.size(), 0);
        check_value("pending_seq_err", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
